imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_W, default 16, sets the immediate output width; legal values are >= 16.
REQ-002 Parameter TAG_W, default 16, sets the width of the sideband tag (e.g. PC) carried with each instruction.
REQ-003 Parameter WORD_SHIFT, default 0, sets the LW/SW offset left-shift amount; legal values are 0 and 1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous discard of all buffered entries.
REQ-007 in_valid  input  1  instr/in_tag are valid this cycle.
REQ-008 in_ready  output  1  the block accepts an entry this cycle.
REQ-009 instr  input  16  instruction word; opcode is instr[15:12].
REQ-010 in_tag  input  TAG_W  tag travelling with instr.
REQ-011 out_valid  output  1  head entry is valid.
REQ-012 out_ready  input  1  the consumer takes the head entry this cycle.
REQ-013 imm_out  output  DATA_W  extended immediate of the head entry.
REQ-014 imm_used  output  1  the head opcode carries an immediate.
REQ-015 out_tag  output  TAG_W  tag of the head entry.

Function
REQ-016 Opcodes 0100, 0101 and 0110 SHALL zero-extend instr[3:0] to DATA_W; imm_used=1.
REQ-017 Opcodes 1000 and 1001 SHALL sign-extend instr[3:0] to DATA_W, then shift left by WORD_SHIFT with a zero fill; imm_used=1.
REQ-018 Opcode 1010 SHALL sign-extend instr[7:0]; imm_used=1.
REQ-019 Opcode 1011 SHALL zero-extend instr[7:0]; imm_used=1.
REQ-020 Opcodes 1100, 1101 and 1110 SHALL sign-extend instr[8:0]; imm_used=1.
REQ-021 All other opcodes SHALL produce imm_out=0 and imm_used=0, and SHALL still pass through the buffer.
REQ-022 Extension SHALL happen before buffering; each buffer entry stores {imm, imm_used, tag}.
REQ-023 The buffer SHALL be a 2-entry FIFO (skid buffer) with occupancy count 0..2.
REQ-024 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-025 in_ready SHALL equal (count != 2) while rst_n is high, and SHALL be 0 while rst_n is low.
REQ-026 out_valid SHALL equal (count != 0); the outputs present the oldest entry.
REQ-027 Latency: an entry pushed in cycle N into an empty buffer SHALL appear on out_valid in cycle N+1; there is no combinational bypass.
REQ-028 Simultaneous push and pop at count=1 SHALL leave count at 1; the new entry becomes the head in the next cycle.
REQ-029 At count=2 no push SHALL occur; a pop SHALL take count to 1, and in_ready SHALL rise the next cycle.
REQ-030 Head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-031 flush SHALL take count to 0 on the next edge, overriding a push or pop in the same cycle; out_valid=0 the following cycle.
REQ-032 Read and write pointers SHALL wrap modulo 2.

Reset
REQ-033 rst_n low SHALL immediately clear count, both pointers, out_valid, imm_out, imm_used and out_tag to 0, without waiting for a clock edge.
REQ-034 On release of rst_n, in_ready SHALL be 1 and the first push is accepted on the next rising edge.
REQ-035 Asserting rst_n mid-transfer SHALL discard all entries; no stale entry SHALL appear after release.

Verification
REQ-036 DATA_W=16: push 0x8AAD, 0xAAA4, 0xEB24, 0xDABE, 0x4AAF with out_ready=1 -> imm_out 0xFFFD, 0xFFA4, 0xFF24, 0x00BE, 0x000F in order, one per cycle, each 1 cycle after its push.
REQ-037 DATA_W=32, WORD_SHIFT=1: push 0x9AAD -> imm_out 0xFFFFFFFA; push 0xBA25 -> 0x00000025; push 0x0123 -> imm_out 0, imm_used 0.
REQ-038 Backpressure: out_ready=0, push 3 entries -> in_ready=0 after 2 pushes, 3rd not accepted; raise out_ready -> 2 entries out in order with tags intact, outputs stable while stalled.
REQ-039 Simultaneous push/pop at count=1 over 10 cycles -> count stays 1, out_valid is continuously 1, no entry lost or duplicated.
REQ-040 Flush with count=2 and in_valid=1 in the same cycle -> out_valid=0 next cycle and the flushed-cycle instruction never emerges.
REQ-041 Assert rst_n low between clock edges with count=1 -> out_valid and imm_out go to 0 immediately; after release in_ready=1 and out_valid=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate extraction/extension ahead of a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 16,
  parameter int WORD_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              imm_used,
  output logic [TAG_W-1:0]  out_tag
);

  // One buffer entry is {imm, imm_used, tag}, packed MSB to LSB.
  localparam int ENT_W    = DATA_W + 1 + TAG_W;
  localparam int USED_BIT = TAG_W;
  localparam int IMM_LSB  = TAG_W + 1;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] zext4;
  logic [DATA_W-1:0] sext4;
  logic [DATA_W-1:0] sext8;
  logic [DATA_W-1:0] zext8;
  logic [DATA_W-1:0] sext9;
  logic [DATA_W-1:0] ext_imm;
  logic              ext_used;
  logic [ENT_W-1:0]  ext_entry;

  // instr[11:9] never feeds any immediate format.
  logic              unused_instr_bits;

  logic [ENT_W-1:0]  mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  head;

  assign opcode            = instr[15:12];
  assign unused_instr_bits = ^instr[11:9];

  // Candidate extensions of each immediate field; the opcode picks one.
  assign zext4 = {{(DATA_W-4){1'b0}}, instr[3:0]};
  assign sext4 = {{(DATA_W-4){instr[3]}}, instr[3:0]};
  assign sext8 = {{(DATA_W-8){instr[7]}}, instr[7:0]};
  assign zext8 = {{(DATA_W-8){1'b0}}, instr[7:0]};
  assign sext9 = {{(DATA_W-9){instr[8]}}, instr[8:0]};

  // Opcode decode: select the immediate and flag whether the opcode carries one.
  always_comb begin
    ext_imm  = '0;
    ext_used = 1'b0;
    case (opcode)
      4'h4, 4'h5, 4'h6: begin
        ext_imm  = zext4;
        ext_used = 1'b1;
      end
      4'h8, 4'h9: begin
        // Load/store offsets may be scaled to a word address.
        ext_imm  = sext4 << WORD_SHIFT;
        ext_used = 1'b1;
      end
      4'hA: begin
        ext_imm  = sext8;
        ext_used = 1'b1;
      end
      4'hB: begin
        ext_imm  = zext8;
        ext_used = 1'b1;
      end
      4'hC, 4'hD, 4'hE: begin
        ext_imm  = sext9;
        ext_used = 1'b1;
      end
      default: begin
        ext_imm  = '0;
        ext_used = 1'b0;
      end
    endcase
  end

  assign ext_entry = {ext_imm, ext_used, in_tag};

  // Handshakes; in_ready is forced low while reset is held.
  assign in_ready  = rst_n & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy and pointers; flush discards everything and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= ext_entry;
    end
  end

  // Head outputs are gated by out_valid so reset clears them without a clock edge.
  assign head     = mem[rd_ptr];
  assign imm_out  = out_valid ? head[ENT_W-1:IMM_LSB] : '0;
  assign imm_used = out_valid ? head[USED_BIT] : 1'b0;
  assign out_tag  = out_valid ? head[TAG_W-1:0] : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] instr;
  logic [15:0] in_tag;
  logic        out_ready;

  logic        in_ready16, out_valid16, used16;
  logic [15:0] imm16, tag16;
  logic        in_ready32, out_valid32, used32;
  logic [31:0] imm32;
  logic [15:0] tag32;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] tag;
  } ent_t;
  ent_t q[$];

  imm_gen_pipe #(.DATA_W(16), .TAG_W(16), .WORD_SHIFT(0)) u16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready16),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid16), .out_ready(out_ready),
    .imm_out(imm16), .imm_used(used16), .out_tag(tag16)
  );

  imm_gen_pipe #(.DATA_W(32), .TAG_W(16), .WORD_SHIFT(1)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_out(imm32), .imm_used(used32), .out_tag(tag32)
  );

  always #5 clk = ~clk;

  // Reference immediate as a signed integer, from the decode table.
  function automatic int ref_imm(input logic [15:0] i, input int ws, output bit used);
    int op;
    int v;
    op   = int'(i[15:12]);
    used = 1'b1;
    if (op >= 4 && op <= 6) return int'(i[3:0]);
    if (op == 8 || op == 9) begin
      v = int'(i[3:0]);
      if (v >= 8) v = v - 16;
      return v * (1 << ws);
    end
    if (op == 10) begin
      v = int'(i[7:0]);
      if (v >= 128) v = v - 256;
      return v;
    end
    if (op == 11) return int'(i[7:0]);
    if (op >= 12 && op <= 14) begin
      v = int'(i[8:0]);
      if (v >= 256) v = v - 512;
      return v;
    end
    used = 1'b0;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready before the edge, update the model, check the head after.
  task automatic tick();
    bit   push;
    bit   pop;
    bit   u;
    int   e16;
    int   e32;
    logic [31:0] w;
    check("in_ready16", {31'b0, in_ready16}, {31'b0, (q.size() != 2) && rst_n});
    check("in_ready32", {31'b0, in_ready32}, {31'b0, (q.size() != 2) && rst_n});
    push = rst_n && in_valid && (q.size() < 2);
    pop  = rst_n && out_ready && (q.size() > 0);
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{instr: instr, tag: in_tag});
    end
    #1;
    check("out_valid16", {31'b0, out_valid16}, {31'b0, q.size() != 0});
    check("out_valid32", {31'b0, out_valid32}, {31'b0, q.size() != 0});
    if (q.size() != 0) begin
      e16 = ref_imm(q[0].instr, 0, u);
      w   = e16;
      check("imm16", {16'b0, imm16}, {16'b0, w[15:0]});
      check("used16", {31'b0, used16}, {31'b0, u});
      check("tag16", {16'b0, tag16}, {16'b0, q[0].tag});
      e32 = ref_imm(q[0].instr, 1, u);
      check("imm32", imm32, e32);
      check("used32", {31'b0, used32}, {31'b0, u});
      check("tag32", {16'b0, tag32}, {16'b0, q[0].tag});
    end
  endtask

  logic [15:0] v36 [5];
  logic [15:0] e36 [5];
  logic [15:0] v37 [3];
  logic [31:0] e37 [3];
  logic        u37 [3];

  initial begin
    checks = 0;
    errors = 0;
    v36 = '{16'h8AAD, 16'hAAA4, 16'hEB24, 16'hDABE, 16'h4AAF};
    e36 = '{16'hFFFD, 16'hFFA4, 16'hFF24, 16'h00BE, 16'h000F};
    v37 = '{16'h9AAD, 16'hBA25, 16'h0123};
    e37 = '{32'hFFFFFFFA, 32'h00000025, 32'h00000000};
    u37 = '{1'b1, 1'b1, 1'b0};

    flush = 0; in_valid = 0; instr = 0; in_tag = 0; out_ready = 0;
    rst_n = 1;
    #2 rst_n = 0;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready16}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid16}, 32'd0);
    check("rst_imm", {16'b0, imm16}, 32'd0);
    check("rst_tag", {16'b0, tag16}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    check("release_in_ready", {31'b0, in_ready16}, 32'd1);

    // Known vectors at DATA_W=16, streaming with the consumer always ready.
    out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; instr = v36[k]; in_tag = 16'(100 + k);
      tick();
      check("vec16_imm", {16'b0, imm16}, {16'b0, e36[k]});
    end
    in_valid = 0;
    tick();

    // Known vectors at DATA_W=32 with scaled load/store offsets.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; instr = v37[k]; in_tag = 16'(200 + k);
      tick();
      check("vec32_imm", imm32, e37[k]);
      check("vec32_used", {31'b0, used32}, {31'b0, u37[k]});
    end
    in_valid = 0;
    tick();

    // Backpressure: third push refused, head stable while stalled, drain in order.
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; instr = 16'($urandom); in_tag = 16'(300 + k);
      if (k == 2) check("bp_full", {31'b0, in_ready16}, 32'd0);
      tick();
    end
    in_valid = 0;
    tick(); tick();
    out_ready = 1;
    tick(); tick(); tick();

    // Simultaneous push and pop at occupancy one.
    out_ready = 0; in_valid = 1; instr = 16'hA1F0; in_tag = 16'd400;
    tick();
    out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      instr = 16'($urandom); in_tag = 16'(401 + k);
      tick();
      check("pp_valid", {31'b0, out_valid16}, 32'd1);
    end
    in_valid = 0;
    tick(); tick();

    // Flush with a full buffer and a push in the same cycle.
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 2; k++) begin
      instr = 16'($urandom); in_tag = 16'(500 + k);
      tick();
    end
    flush = 1; instr = 16'hC0FF; in_tag = 16'd555;
    tick();
    flush = 0; in_valid = 0;
    check("flush_valid", {31'b0, out_valid16}, 32'd0);
    out_ready = 1;
    tick(); tick(); tick();

    // Asynchronous reset between edges with one entry buffered.
    out_ready = 0; in_valid = 1; instr = 16'hB0A5; in_tag = 16'd600;
    tick();
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("async_valid", {31'b0, out_valid16}, 32'd0);
    check("async_imm16", {16'b0, imm16}, 32'd0);
    check("async_imm32", imm32, 32'd0);
    check("async_in_ready", {31'b0, in_ready16}, 32'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_rst_ready", {31'b0, in_ready16}, 32'd1);
    check("post_rst_valid", {31'b0, out_valid16}, 32'd0);
    out_ready = 1;
    tick(); tick();

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      instr     = 16'($urandom);
      in_tag    = 16'($urandom);
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
